// File: rtl/sipo_rx_ctrl_if.sv
// Output handshake bundle of the SIPO receiver: assembled word plus valid/ready.
// The receiver drives through the master modport; the consumer uses the slave modport.
interface sipo_rx_ctrl_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/sipo_rx_ctrl.sv
// Receive sequencer for the serial-in/parallel-out path: start detect, bit assembly,
// stop check, and a one-word holding register with sticky overrun/framing flags.
module sipo_rx_ctrl #(
    parameter int DATA_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en_i,
    input  logic           bit_en_i,
    input  logic           serial_in_i,
    input  logic           clr_err_i,
    sipo_rx_ctrl_if.master out_if,
    output logic           busy_o,
    output logic           overrun_o,
    output logic           frame_err_o
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;
    logic                frameErr_q, frameErr_d;
    logic                wordDone;
    logic                stopBad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            shift_q    <= '0;
            hold_q     <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            frameErr_q <= frameErr_d;
        end
    end

    // Frame sequencing: every move needs both the enable and a sample strobe.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        shift_d  = shift_q;
        wordDone = 1'b0;
        stopBad  = 1'b0;
        if (!en_i) begin
            state_d = IDLE;
            count_d = '0;
        end else if (bit_en_i) begin
            case (state_q)
                IDLE: begin
                    if (!serial_in_i) begin
                        state_d = DATA;
                        count_d = '0;
                    end
                end
                DATA: begin
                    if (MSB_FIRST) begin
                        shift_d = {shift_q[DATA_W-2:0], serial_in_i};
                    end else begin
                        shift_d = {serial_in_i, shift_q[DATA_W-1:1]};
                    end
                    if (count_q == CNT_W'(DATA_W - 1)) begin
                        state_d = STOP;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    state_d = IDLE;
                    if (serial_in_i) begin
                        wordDone = 1'b1;
                    end else begin
                        stopBad = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // A completed word only replaces the held one if that one is gone or leaving now;
    // set events are applied after the clear so they win a same-cycle collision.
    always_comb begin
        hold_d     = hold_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q;
        frameErr_d = frameErr_q;
        if (valid_q && out_if.ready) begin
            valid_d = 1'b0;
        end
        if (clr_err_i) begin
            overrun_d  = 1'b0;
            frameErr_d = 1'b0;
        end
        if (wordDone) begin
            if (valid_q && !out_if.ready) begin
                overrun_d = 1'b1;
            end else begin
                hold_d  = shift_q;
                valid_d = 1'b1;
            end
        end
        if (stopBad) begin
            frameErr_d = 1'b1;
        end
    end

    assign out_if.data  = hold_q;
    assign out_if.valid = valid_q;
    assign busy_o       = (state_q != IDLE);
    assign overrun_o    = overrun_q;
    assign frame_err_o  = frameErr_q;

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Directed bench for sipo_rx_ctrl: an MSB-first and an LSB-first instance share the
// serial stimulus; each scenario task checks its own hand-computed expectations.
module tb_sipo_rx_ctrl;

    logic clk;
    logic reset;
    logic en;
    logic bitEn;
    logic serialIn;
    logic clrErr;
    logic busyA, overrunA, frameErrA;
    logic busyB, overrunB, frameErrB;

    int compared;
    int mismatched;

    sipo_rx_ctrl_if #(.DATA_W(8)) ifA ();
    sipo_rx_ctrl_if #(.DATA_W(8)) ifB ();

    sipo_rx_ctrl #(.DATA_W(8), .MSB_FIRST(1'b1)) dutA (
        .clk         (clk),
        .reset       (reset),
        .en_i        (en),
        .bit_en_i    (bitEn),
        .serial_in_i (serialIn),
        .clr_err_i   (clrErr),
        .out_if      (ifA.master),
        .busy_o      (busyA),
        .overrun_o   (overrunA),
        .frame_err_o (frameErrA)
    );

    sipo_rx_ctrl #(.DATA_W(8), .MSB_FIRST(1'b0)) dutB (
        .clk         (clk),
        .reset       (reset),
        .en_i        (en),
        .bit_en_i    (bitEn),
        .serial_in_i (serialIn),
        .clr_err_i   (clrErr),
        .out_if      (ifB.master),
        .busy_o      (busyB),
        .overrun_o   (overrunB),
        .frame_err_o (frameErrB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle cycles toggle the line to show it is ignored without a strobe.
    task automatic sendBit(input logic b, input int gap);
        for (int i = 0; i < gap; i++) begin
            bitEn    = 1'b0;
            serialIn = ~serialIn;
            tick();
        end
        serialIn = b;
        bitEn    = 1'b1;
        tick();
        bitEn = 1'b0;
    endtask

    task automatic sendHead(input logic [7:0] word, input int gap);
        sendBit(1'b0, gap);
        for (int i = 7; i >= 0; i--) begin
            sendBit(word[i], gap);
        end
    endtask

    task automatic sendFrame(input logic [7:0] word, input logic stopBit, input int gap);
        sendHead(word, gap);
        sendBit(stopBit, gap);
        serialIn = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        compared++;
        if (busyA !== 1'b0 || ifA.valid !== 1'b0 || ifA.data !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: busy=%b valid=%b data=%h expected 0 0 00", busyA, ifA.valid, ifA.data);
        end
        compared++;
        if (overrunA !== 1'b0 || frameErrA !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: overrun=%b frame_err=%b expected 0 0", overrunA, frameErrA);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        ifA.ready = 1'b1;
        sendFrame(8'hA5, 1'b1, 0);
        compared++;
        if (ifA.valid !== 1'b1 || ifA.data !== 8'hA5) begin
            mismatched++;
            $display("[TB] FAIL basic_deliver: valid=%b data=%h expected 1 a5", ifA.valid, ifA.data);
        end
        compared++;
        if (overrunA !== 1'b0 || frameErrA !== 1'b0 || busyA !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL basic_status: overrun=%b frame_err=%b busy=%b expected 0 0 0", overrunA, frameErrA, busyA);
        end
        tick();
        compared++;
        if (ifA.valid !== 1'b0 || ifA.data !== 8'hA5) begin
            mismatched++;
            $display("[TB] FAIL basic_consumed: valid=%b data=%h expected 0 a5", ifA.valid, ifA.data);
        end
    endtask

    task automatic test_slow_strobe();
        sendFrame(8'h3C, 1'b1, 3);
        compared++;
        if (ifA.valid !== 1'b1 || ifA.data !== 8'h3C) begin
            mismatched++;
            $display("[TB] FAIL slow_strobe: valid=%b data=%h expected 1 3c", ifA.valid, ifA.data);
        end
        tick();
    endtask

    task automatic test_frame_err();
        sendFrame(8'hFF, 1'b0, 0);
        compared++;
        if (frameErrA !== 1'b1 || ifA.valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL frame_err_set: frame_err=%b valid=%b expected 1 0", frameErrA, ifA.valid);
        end
        clrErr = 1'b1;
        tick();
        clrErr = 1'b0;
        compared++;
        if (frameErrA !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL frame_err_clear: frame_err=%b expected 0", frameErrA);
        end
        sendHead(8'hFF, 0);
        clrErr = 1'b1;
        sendBit(1'b0, 0);
        clrErr   = 1'b0;
        serialIn = 1'b1;
        compared++;
        if (frameErrA !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL frame_err_set_wins: frame_err=%b expected 1", frameErrA);
        end
        clrErr = 1'b1;
        tick();
        clrErr = 1'b0;
    endtask

    task automatic test_overrun();
        ifA.ready = 1'b0;
        sendFrame(8'h3C, 1'b1, 0);
        compared++;
        if (ifA.valid !== 1'b1 || ifA.data !== 8'h3C || overrunA !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL overrun_first: valid=%b data=%h overrun=%b expected 1 3c 0", ifA.valid, ifA.data, overrunA);
        end
        sendFrame(8'hC3, 1'b1, 0);
        compared++;
        if (ifA.valid !== 1'b1 || ifA.data !== 8'h3C || overrunA !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL overrun_second: valid=%b data=%h overrun=%b expected 1 3c 1", ifA.valid, ifA.data, overrunA);
        end
        ifA.ready = 1'b1;
        tick();
        compared++;
        if (ifA.valid !== 1'b0 || ifA.data !== 8'h3C) begin
            mismatched++;
            $display("[TB] FAIL overrun_accept: valid=%b data=%h expected 0 3c", ifA.valid, ifA.data);
        end
        clrErr = 1'b1;
        tick();
        clrErr = 1'b0;
        compared++;
        if (overrunA !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL overrun_clear: overrun=%b expected 0", overrunA);
        end
    endtask

    task automatic test_back_to_back();
        ifA.ready = 1'b0;
        sendFrame(8'h5A, 1'b1, 0);
        sendHead(8'h96, 0);
        ifA.ready = 1'b1;
        sendBit(1'b1, 0);
        serialIn = 1'b1;
        compared++;
        if (ifA.valid !== 1'b1 || ifA.data !== 8'h96 || overrunA !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_replace: valid=%b data=%h overrun=%b expected 1 96 0", ifA.valid, ifA.data, overrunA);
        end
        tick();
        compared++;
        if (ifA.valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_drain: valid=%b expected 0", ifA.valid);
        end
    endtask

    task automatic test_mid_reset();
        sendHead(8'hF0, 0);
        compared++;
        if (busyA !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL midreset_busy_before: busy=%b expected 1", busyA);
        end
        #2;
        reset = 1'b1;
        #1;
        compared++;
        if (busyA !== 1'b0 || ifA.valid !== 1'b0 || ifA.data !== 8'h00 || overrunA !== 1'b0 || frameErrA !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL midreset_clear: busy=%b valid=%b data=%h ovr=%b ferr=%b expected 0 0 00 0 0",
                     busyA, ifA.valid, ifA.data, overrunA, frameErrA);
        end
        tick();
        reset = 1'b0;
        tick();
        sendFrame(8'h81, 1'b1, 0);
        compared++;
        if (ifA.valid !== 1'b1 || ifA.data !== 8'h81) begin
            mismatched++;
            $display("[TB] FAIL midreset_next: valid=%b data=%h expected 1 81", ifA.valid, ifA.data);
        end
        tick();
    endtask

    task automatic test_lsb_first_and_enable();
        sendFrame(8'h80, 1'b1, 0);
        compared++;
        if (ifB.valid !== 1'b1 || ifB.data !== 8'h01) begin
            mismatched++;
            $display("[TB] FAIL lsb_first: valid=%b data=%h expected 1 01", ifB.valid, ifB.data);
        end
        compared++;
        if (ifA.data !== 8'h80) begin
            mismatched++;
            $display("[TB] FAIL msb_first_same_bits: data=%h expected 80", ifA.data);
        end
        tick();
        sendBit(1'b0, 0);
        sendBit(1'b1, 0);
        sendBit(1'b0, 0);
        compared++;
        if (busyA !== 1'b1 || busyB !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL en_busy_before: busyA=%b busyB=%b expected 1 1", busyA, busyB);
        end
        en = 1'b0;
        tick();
        compared++;
        if (busyA !== 1'b0 || busyB !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL en_drop_idle: busyA=%b busyB=%b expected 0 0", busyA, busyB);
        end
        compared++;
        if (ifA.data !== 8'h80 || ifB.data !== 8'h01) begin
            mismatched++;
            $display("[TB] FAIL en_drop_hold: dataA=%h dataB=%h expected 80 01", ifA.data, ifB.data);
        end
        en       = 1'b1;
        serialIn = 1'b1;
        tick();
        sendFrame(8'h5A, 1'b1, 0);
        compared++;
        if (ifA.valid !== 1'b1 || ifA.data !== 8'h5A) begin
            mismatched++;
            $display("[TB] FAIL en_recover: valid=%b data=%h expected 1 5a", ifA.valid, ifA.data);
        end
        tick();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        en         = 1'b1;
        bitEn      = 1'b0;
        serialIn   = 1'b1;
        clrErr     = 1'b0;
        ifA.ready  = 1'b1;
        ifB.ready  = 1'b1;

        test_reset();
        test_basic();
        test_slow_strobe();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_mid_reset();
        test_lsb_first_and_enable();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
